// File: rtl/ev21g1_pkg.sv
// EV21G1 three-stage microcoded datapath.
// Shared field layout, encodings and stage bundles.
package ev21g1_pkg;

  localparam int DW = 32;
  localparam int KW = 16;
  localparam int RW = 6;
  localparam int ALUC_W = 4;
  localparam int SH_W = 3;
  localparam int NREGS = 60;

  localparam int PRINT_BIT = 0;
  localparam int FLIP_BIT = PRINT_BIT + 1;
  localparam int C_LSB = FLIP_BIT + 1;
  localparam int B_LSB = C_LSB + RW;
  localparam int A_LSB = B_LSB + RW;
  localparam int WRITE_BIT = A_LSB + RW;
  localparam int READ_BIT = WRITE_BIT + 1;
  localparam int KMX_BIT = READ_BIT + 1;
  localparam int SH_LSB = KMX_BIT + 1;
  localparam int ALUC_LSB = SH_LSB + SH_W;
  localparam int UW = ALUC_LSB + ALUC_W;

  localparam logic [RW-1:0] NULL_REG = 6'd63;
  localparam logic [RW-1:0] IN0_REG = 6'd60;
  localparam logic [RW-1:0] IN1_REG = 6'd61;

  typedef enum logic [ALUC_W-1:0] {
    ALU_A = 4'h0, ALU_B, ALU_NOTA, ALU_NOTB,
    ALU_ADD, ALU_ADC, ALU_OR, ALU_AND,
    ALU_XOR, ALU_SUB, ALU_INC, ALU_CLC,
    ALU_SEC, ALU_RSV0, ALU_RSV1, ALU_RSV2
  } aluc_e;

  typedef enum logic [SH_W-1:0] {
    SH_NONE, SH_SHL1, SH_SHR1, SH_SHL16,
    SH_SHR16, SH_SAR1, SH_ROL1, SH_ROR1
  } sh_e;

  typedef struct packed {
    aluc_e         aluc;
    sh_e           sh;
    logic          kmx;
    logic          rd;
    logic          wr;
    logic [RW-1:0] a;
    logic [RW-1:0] b;
    logic [RW-1:0] c;
    logic          flip;
    logic          prt;
  } uinstr_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    aluc_e         aluc;
    sh_e           sh;
    logic [RW-1:0] c;
    logic          rd;
    logic          wr;
    logic          flip;
    logic          prt;
  } id_ex_t;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [DW-1:0] b;
    logic [RW-1:0] c;
    logic          rd;
    logic          wr;
    logic          flip;
    logic          prt;
  } ex_wb_t;

  localparam id_ex_t ID_EX_NOP = '{
    a: '0, b: '0, aluc: ALU_A, sh: SH_NONE,
    c: NULL_REG, rd: 1'b0, wr: 1'b0,
    flip: 1'b0, prt: 1'b0
  };

  localparam ex_wb_t EX_WB_NOP = '{
    res: '0, b: '0, c: NULL_REG, rd: 1'b0,
    wr: 1'b0, flip: 1'b0, prt: 1'b0
  };

endpackage

// File: rtl/ev21g1_if.sv
// EV21G1 instruction, port and memory-strobe bundle.
// master drives microcode and inputs; slave is the datapath.
interface ev21g1_if;
  import ev21g1_pkg::*;

  logic [UW-1:0] microinstruction;
  logic [KW-1:0] k;
  logic [DW-1:0] input_port0;
  logic [DW-1:0] input_port1;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_addr_bus;
  logic [DW-1:0] output_port0;
  logic [DW-1:0] output_port1;

  modport master (
    output microinstruction, k,
    output input_port0, input_port1,
    input  mem_read, mem_write, mem_addr_bus,
    input  output_port0, output_port1
  );

  modport slave (
    input  microinstruction, k,
    input  input_port0, input_port1,
    output mem_read, mem_write, mem_addr_bus,
    output output_port0, output_port1
  );

endinterface

// File: rtl/ev21g1_alu.sv
// EV21G1 combinational ALU, shifter and carry logic.
// cy_o echoes cy_i for codes that leave the carry alone.
module ev21g1_alu
  import ev21g1_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  aluc_e         aluc,
  input  sh_e           sh,
  input  logic          cy_i,
  output logic [DW-1:0] res,
  output logic          cy_o,
  output logic          fl_upd
);

  logic [DW:0]   sum;
  logic [DW-1:0] alu_r;

  always_comb begin
    sum = '0;
    alu_r = b;
    cy_o = cy_i;
    fl_upd = 1'b1;
    unique case (aluc)
      ALU_A:    alu_r = a;
      ALU_B:    alu_r = b;
      ALU_NOTA: alu_r = ~a;
      ALU_NOTB: alu_r = ~b;
      ALU_ADD: begin
        sum = {1'b0, a} + {1'b0, b};
        alu_r = sum[DW-1:0];
        cy_o = sum[DW];
      end
      ALU_ADC: begin
        sum = {1'b0, a} + {1'b0, b}
            + {{DW{1'b0}}, cy_i};
        alu_r = sum[DW-1:0];
        cy_o = sum[DW];
      end
      ALU_OR:   alu_r = a | b;
      ALU_AND:  alu_r = a & b;
      ALU_XOR:  alu_r = a ^ b;
      // bit DW of the widened difference is the borrow
      ALU_SUB: begin
        sum = {1'b0, a} - {1'b0, b};
        alu_r = sum[DW-1:0];
        cy_o = sum[DW];
      end
      ALU_INC: begin
        sum = {1'b0, b} + {{DW{1'b0}}, 1'b1};
        alu_r = sum[DW-1:0];
        cy_o = sum[DW];
      end
      ALU_CLC: begin
        alu_r = a;
        cy_o = 1'b0;
      end
      ALU_SEC: begin
        alu_r = a;
        cy_o = 1'b1;
      end
      default: begin
        alu_r = b;
        fl_upd = 1'b0;
      end
    endcase
  end

  always_comb begin
    res = alu_r;
    unique case (sh)
      SH_NONE:  res = alu_r;
      SH_SHL1:  res = {alu_r[DW-2:0], 1'b0};
      SH_SHR1:  res = {1'b0, alu_r[DW-1:1]};
      SH_SHL16: res = {alu_r[15:0], 16'h0};
      SH_SHR16: res = {16'h0, alu_r[DW-1:16]};
      SH_SAR1:  res = {alu_r[DW-1], alu_r[DW-1:1]};
      SH_ROL1:  res = {alu_r[DW-2:0], alu_r[DW-1]};
      SH_ROR1:  res = {alu_r[0], alu_r[DW-1:1]};
      default:  res = alu_r;
    endcase
  end

endmodule

// File: rtl/ev21g1.sv
// EV21G1 top: register file, three pipeline stages,
// memory strobes and registered output ports.
module ev21g1
  import ev21g1_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ev21g1_if.slave       bus,
  inout  wire [DW-1:0]  mem_data_bus
);

  uinstr_t       ui;
  logic [DW-1:0] rf_q [NREGS];
  logic [DW-1:0] rf_d [NREGS];
  id_ex_t        s1_q, s1_d;
  ex_wb_t        s2_q, s2_d;
  logic          cy_q, cy_d;
  logic          z_q, z_d;
  logic          n_q, n_d;
  logic [DW-1:0] out0_q, out0_d;
  logic [DW-1:0] out1_q, out1_d;
  logic [DW-1:0] op_a, op_b, wb_val;
  logic [DW-1:0] alu_res;
  logic          alu_cy, alu_upd;

  assign ui = uinstr_t'(bus.microinstruction);

  always_comb begin
    op_a = '0;
    op_b = '0;
    if (ui.a < IN0_REG) op_a = rf_q[ui.a];
    else if (ui.a == IN0_REG) op_a = bus.input_port0;
    else if (ui.a == IN1_REG) op_a = bus.input_port1;
    if (ui.kmx) op_a = {{(DW-KW){1'b0}}, bus.k};
    if (ui.b < IN0_REG) op_b = rf_q[ui.b];
    else if (ui.b == IN0_REG) op_b = bus.input_port0;
    else if (ui.b == IN1_REG) op_b = bus.input_port1;
  end

  always_comb begin
    s1_d = '{
      a: op_a, b: op_b, aluc: ui.aluc, sh: ui.sh,
      c: ui.c, rd: ui.rd, wr: ui.wr,
      flip: ui.flip, prt: ui.prt
    };
  end

  ev21g1_alu u_alu (
    .a      (s1_q.a),
    .b      (s1_q.b),
    .aluc   (s1_q.aluc),
    .sh     (s1_q.sh),
    .cy_i   (cy_q),
    .res    (alu_res),
    .cy_o   (alu_cy),
    .fl_upd (alu_upd)
  );

  // write wins over read, so rd is cleared here
  always_comb begin
    s2_d = '{
      res: alu_res, b: s1_q.b, c: s1_q.c,
      rd: s1_q.rd & ~s1_q.wr, wr: s1_q.wr,
      flip: s1_q.flip, prt: s1_q.prt
    };
    cy_d = alu_cy;
    z_d = z_q;
    n_d = n_q;
    if (alu_upd) begin
      z_d = (alu_res == '0);
      n_d = alu_res[DW-1];
    end
  end

  always_comb begin
    wb_val = s2_q.rd ? mem_data_bus : s2_q.res;
    rf_d = rf_q;
    if (s2_q.c < IN0_REG) rf_d[s2_q.c] = wb_val;
    out0_d = out0_q;
    out1_d = out1_q;
    unique case (1'b1)
      s2_q.prt & ~s2_q.flip: out0_d = s2_q.res;
      s2_q.prt & s2_q.flip:  out1_d = s2_q.res;
      default: ;
    endcase
  end

  assign bus.mem_read = s2_q.rd;
  assign bus.mem_write = s2_q.wr;
  assign bus.mem_addr_bus =
    (s2_q.rd | s2_q.wr) ? s2_q.res : '0;
  assign mem_data_bus = s2_q.wr ? s2_q.b : 'z;
  assign bus.output_port0 = out0_q;
  assign bus.output_port1 = out1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= ID_EX_NOP;
      s2_q <= EX_WB_NOP;
      cy_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      out0_q <= '0;
      out1_q <= '0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      cy_q <= cy_d;
      z_q <= z_d;
      n_q <= n_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
      rf_q <= rf_d;
    end
  end

endmodule

// File: tb/tb_ev21g1.sv
// EV21G1 bench: directed program vectors plus random
// microcode against a sequential instruction-level model.
module tb_ev21g1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_run = 0;
  int n_fail = 0;

  ev21g1_if bus ();
  wire [31:0] mem_data_bus;

  ev21g1 dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .mem_data_bus (mem_data_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_fn(logic [31:0] ad);
    return ad ^ 32'hA5A5_5A5A;
  endfunction

  assign mem_data_bus =
    bus.mem_read ? mem_fn(bus.mem_addr_bus) : 32'bz;

  function automatic logic [29:0] mk(
    int al, int sh, int km, int rd, int wr,
    int a, int b, int c, int fl, int pr);
    return {4'(al), 3'(sh), 1'(km), 1'(rd), 1'(wr),
            6'(a), 6'(b), 6'(c), 1'(fl), 1'(pr)};
  endfunction

  localparam logic [29:0] NOP = 30'h0000_00FC;

  logic [31:0] m_rf [64];
  logic        m_cy;
  logic [31:0] m_o0, m_o1;

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_rf[i] = '0;
    m_cy = 1'b0;
    m_o0 = '0;
    m_o1 = '0;
  endtask

  function automatic logic [31:0] m_get(logic [5:0] r);
    if (r < 6'd60) return m_rf[r];
    if (r == 6'd60) return bus.input_port0;
    if (r == 6'd61) return bus.input_port1;
    return 32'h0;
  endfunction

  task automatic m_step(input logic [29:0] ui,
                        input logic [15:0] kk);
    logic [31:0] a, b, r;
    logic [32:0] w;
    a = ui[22] ? {16'h0, kk} : m_get(ui[19:14]);
    b = m_get(ui[13:8]);
    r = b;
    case (ui[29:26])
      4'd0: r = a;
      4'd1: r = b;
      4'd2: r = ~a;
      4'd3: r = ~b;
      4'd4: begin
        w = 33'(a) + 33'(b);
        r = w[31:0]; m_cy = w[32];
      end
      4'd5: begin
        w = 33'(a) + 33'(b) + 33'(m_cy);
        r = w[31:0]; m_cy = w[32];
      end
      4'd6: r = a | b;
      4'd7: r = a & b;
      4'd8: r = a ^ b;
      4'd9: begin r = a - b; m_cy = (a < b); end
      4'd10: begin
        w = 33'(b) + 33'd1;
        r = w[31:0]; m_cy = w[32];
      end
      4'd11: begin r = a; m_cy = 1'b0; end
      4'd12: begin r = a; m_cy = 1'b1; end
      default: r = b;
    endcase
    case (ui[25:23])
      3'd1: r = r << 1;
      3'd2: r = r >> 1;
      3'd3: r = r << 16;
      3'd4: r = r >> 16;
      3'd5: r = $signed(r) >>> 1;
      3'd6: r = (r << 1) | (r >> 31);
      3'd7: r = (r >> 1) | (r << 31);
      default: ;
    endcase
    if (ui[7:2] < 6'd60)
      m_rf[ui[7:2]] = (ui[21] && !ui[20]) ? mem_fn(r) : r;
    if (ui[0]) begin
      if (ui[1]) m_o1 = r;
      else m_o0 = r;
    end
  endtask

  task automatic issue(input logic [29:0] ui,
                       input logic [15:0] kk);
    @(negedge clk);
    bus.microinstruction = ui;
    bus.k = kk;
  endtask

  task automatic exec(input logic [29:0] ui,
                      input logic [15:0] kk);
    issue(ui, kk);
    issue(NOP, 16'h0);
    issue(NOP, 16'h0);
    @(negedge clk);
    m_step(ui, kk);
  endtask

  task automatic peek(input int r, output logic [31:0] v);
    exec(mk(1, 0, 0, 0, 0, 0, r, 63, 0, 1), 16'h0);
    v = bus.output_port0;
  endtask

  task automatic peek_cy(output logic [31:0] v);
    exec(mk(5, 0, 0, 0, 0, 62, 62, 63, 0, 1), 16'h0);
    v = bus.output_port0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst_n = 1'b0;
    bus.microinstruction = NOP;
    bus.k = '0;
    bus.input_port0 = 32'hC0DE_0060;
    bus.input_port1 = 32'hC0DE_0061;
    repeat (3) @(negedge clk);
    n_run++;
    if (bus.output_port0 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_out0: got %h want 0", bus.output_port0);
    end
    n_run++;
    if (bus.output_port1 !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_out1: got %h want 0", bus.output_port1);
    end
    n_run++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_strobe: got %b want 00",
               {bus.mem_read, bus.mem_write});
    end
    n_run++;
    if (bus.mem_addr_bus !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_addr: got %h want 0", bus.mem_addr_bus);
    end
    rst_n = 1'b1;
    m_reset();
    peek(7, v);
    n_run++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_r7: got %h want 0", v);
    end
  endtask

  task automatic test_immediates();
    logic [31:0] v;
    for (int i = 0; i < 3; i++)
      exec(mk(0, 0, 1, 0, 0, 0, 0, i, 0, 0), 16'(i));
    for (int i = 0; i < 3; i++) begin
      peek(i, v);
      n_run++;
      if (v !== 32'(i)) begin
        n_fail++;
        $display("FAIL imm_r%0d: got %h want %h", i, v, 32'(i));
      end
    end
  endtask

  task automatic test_shift_not();
    logic [31:0] v;
    exec(mk(0, 3, 1, 0, 0, 0, 0, 3, 0, 0), 16'd3);
    exec(mk(2, 0, 0, 0, 0, 3, 0, 13, 0, 0), 16'h0);
    exec(mk(4, 0, 0, 0, 0, 3, 13, 20, 0, 0), 16'h0);
    peek(3, v);
    n_run++;
    if (v !== 32'h0003_0000) begin
      n_fail++;
      $display("FAIL shl16_r3: got %h want 00030000", v);
    end
    peek(13, v);
    n_run++;
    if (v !== 32'hFFFC_FFFF) begin
      n_fail++;
      $display("FAIL not_r13: got %h want fffcffff", v);
    end
    peek(20, v);
    n_run++;
    if (v !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL add_r20: got %h want ffffffff", v);
    end
    peek_cy(v);
    n_run++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL add_cy: got %h want 0", v);
    end
  endtask

  task automatic test_logic();
    logic [31:0] v;
    exec(mk(7, 0, 0, 0, 0, 20, 13, 21, 0, 0), 16'h0);
    exec(mk(6, 0, 0, 0, 0, 3, 2, 22, 0, 0), 16'h0);
    peek(21, v);
    n_run++;
    if (v !== 32'hFFFC_FFFF) begin
      n_fail++;
      $display("FAIL and_r21: got %h want fffcffff", v);
    end
    peek(22, v);
    n_run++;
    if (v !== 32'h0003_0002) begin
      n_fail++;
      $display("FAIL or_r22: got %h want 00030002", v);
    end
  endtask

  task automatic test_carry_chain();
    logic [31:0] v;
    logic [29:0] sec, adc;
    sec = mk(12, 0, 0, 0, 0, 0, 0, 63, 0, 0);
    adc = mk(5, 0, 0, 0, 0, 3, 13, 20, 0, 0);
    issue(sec, 16'h0);
    issue(adc, 16'h0);
    issue(NOP, 16'h0);
    issue(NOP, 16'h0);
    @(negedge clk);
    m_step(sec, 16'h0);
    m_step(adc, 16'h0);
    peek(20, v);
    n_run++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL adc_r20: got %h want 0", v);
    end
    peek_cy(v);
    n_run++;
    if (v !== 32'h1) begin
      n_fail++;
      $display("FAIL adc_cy: got %h want 1", v);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] v;
    exec(mk(0, 3, 1, 0, 0, 0, 0, 24, 0, 0), 16'h8000);
    exec(mk(0, 3, 1, 0, 0, 0, 0, 23, 0, 0), 16'hFFFF);
    exec(mk(6, 0, 1, 0, 0, 0, 23, 23, 0, 0), 16'hFFFF);
    exec(mk(4, 0, 0, 0, 0, 24, 23, 25, 0, 0), 16'h0);
    peek(25, v);
    n_run++;
    if (v !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL ovf_r25: got %h want 7fffffff", v);
    end
    peek_cy(v);
    n_run++;
    if (v !== 32'h1) begin
      n_fail++;
      $display("FAIL ovf_cy: got %h want 1", v);
    end
  endtask

  task automatic test_ports_mem();
    logic [31:0] v, hold0;
    logic [29:0] ui;
    hold0 = m_o0;
    exec(mk(1, 0, 0, 0, 0, 0, 25, 63, 1, 1), 16'h0);
    n_run++;
    if (bus.output_port1 !== 32'h7FFF_FFFF) begin
      n_fail++;
      $display("FAIL flip_out1: got %h want 7fffffff",
               bus.output_port1);
    end
    n_run++;
    if (bus.output_port0 !== hold0) begin
      n_fail++;
      $display("FAIL flip_out0: got %h want %h",
               bus.output_port0, hold0);
    end
    ui = mk(4, 0, 1, 1, 1, 0, 2, 40, 0, 0);
    issue(ui, 16'h0100);
    issue(NOP, 16'h0);
    issue(NOP, 16'h0);
    #1;
    n_run++;
    if ({bus.mem_write, bus.mem_read} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_strobe: got %b want 10",
               {bus.mem_write, bus.mem_read});
    end
    n_run++;
    if (bus.mem_addr_bus !== 32'h0000_0102) begin
      n_fail++;
      $display("FAIL wr_addr: got %h want 00000102",
               bus.mem_addr_bus);
    end
    n_run++;
    if (mem_data_bus !== 32'h2) begin
      n_fail++;
      $display("FAIL wr_data: got %h want 2", mem_data_bus);
    end
    @(negedge clk);
    m_step(ui, 16'h0100);
    n_run++;
    if (bus.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_len: got %b want 0", bus.mem_write);
    end
    peek(40, v);
    n_run++;
    if (v !== 32'h0000_0102) begin
      n_fail++;
      $display("FAIL wr_r40: got %h want 00000102", v);
    end
    exec(mk(0, 0, 1, 1, 0, 0, 0, 30, 0, 0), 16'h0040);
    peek(30, v);
    n_run++;
    if (v !== 32'hA5A5_5A1A) begin
      n_fail++;
      $display("FAIL rd_r30: got %h want a5a55a1a", v);
    end
    for (int r = 60; r < 63; r++) begin
      peek(r, v);
      n_run++;
      if (v !== m_o0) begin
        n_fail++;
        $display("FAIL rd_r%0d: got %h want %h", r, v, m_o0);
      end
    end
  endtask

  task automatic test_random();
    logic [29:0] ui;
    logic [15:0] kk;
    logic [31:0] v;
    int r;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.input_port0 = $urandom();
        bus.input_port1 = $urandom();
      end
      ui = 30'($urandom());
      kk = 16'($urandom());
      exec(ui, kk);
      n_run++;
      if ({bus.output_port0, bus.output_port1}
          !== {m_o0, m_o1}) begin
        n_fail++;
        $display("FAIL rnd_out%0d: got %h/%h want %h/%h", i,
                 bus.output_port0, bus.output_port1, m_o0, m_o1);
      end
      r = $urandom_range(0, 63);
      peek(r, v);
      n_run++;
      if (v !== m_o0) begin
        n_fail++;
        $display("FAIL rnd_r%0d: got %h want %h", r, v, m_o0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    exec(mk(1, 0, 0, 0, 0, 0, 25, 63, 0, 1), 16'h0);
    issue(mk(0, 0, 1, 0, 1, 0, 0, 5, 0, 1), 16'h1234);
    issue(NOP, 16'h0);
    issue(NOP, 16'h0);
    #1;
    n_run++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: got %b want 1", bus.mem_write);
    end
    rst_n = 1'b0;
    #1;
    n_run++;
    if ({bus.output_port0, bus.output_port1,
         bus.mem_addr_bus} !== 96'h0) begin
      n_fail++;
      $display("FAIL mid_out: got %h/%h/%h want 0",
               bus.output_port0, bus.output_port1,
               bus.mem_addr_bus);
    end
    n_run++;
    if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_strobe: got %b want 00",
               {bus.mem_read, bus.mem_write});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    repeat (2) @(negedge clk);
    n_run++;
    if (bus.output_port0 !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_nowb_out: got %h want 0",
               bus.output_port0);
    end
    peek(5, v);
    n_run++;
    if (v !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_r5: got %h want 0", v);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_immediates();
    test_shift_not();
    test_logic();
    test_carry_chain();
    test_overflow();
    test_ports_mem();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ev21g1.md
EV21G1 -- requirements
Module: ev21g1

Interface
REQ-001 Parameters: none; datapath width is fixed at 32 bits, K width 16 bits, register address width 6 bits.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 input_port0  input  32  external input port, readable as register 60.
REQ-006 input_port1  input  32  external input port, readable as register 61.
REQ-007 k  input  16  immediate constant, zero-extended to 32 bits.
REQ-008 microinstruction  input  30  fields: aluc[29:26], sh[25:23], kmx[22], read[21], write[20], a[19:14], b[13:8], c[7:2], flip[1], print[0].
REQ-009 mem_read  output  1  memory read strobe.
REQ-010 mem_write  output  1  memory write strobe.
REQ-011 mem_addr_bus  output  32  memory address.
REQ-012 mem_data_bus  inout  32  driven only while mem_write=1, high-Z otherwise.
REQ-013 output_port0  output  32  registered output port.
REQ-014 output_port1  output  32  registered output port.

Function
REQ-015 Register file: R0-R59 are 32-bit read/write; R60 and R61 read input_port0/1; R62 reads 0; R63 reads 0; writes to R60-R63 are discarded.
REQ-016 c=63 means no writeback, so an all-zero instruction with c=63 is a NOP.
REQ-017 A operand: zero-extended k when kmx=1, else R[a]; B operand: R[b]; both read combinationally.
REQ-018 Stage 1 (edge n): latch the A and B operands plus aluc, sh, c, read, write, flip and print.
REQ-019 Stage 2 (edge n+1): latch ALU then shifter result; update CY and the Z/N flags.
REQ-020 Stage 3 (edge n+2): write the result to R[c]; the value is readable by an instruction sampled at edge n+3.
REQ-021 No forwarding and no hazard detection; software inserts 2 NOPs between dependent instructions.
REQ-022 aluc 0000: A.
REQ-023 aluc 0001: B.
REQ-024 aluc 0010: ~A.
REQ-025 aluc 0011: ~B.
REQ-026 aluc 0100: A+B; CY = carry out of bit 31.
REQ-027 aluc 0101: A+B+CY; CY = carry out of bit 31.
REQ-028 aluc 0110: A|B.
REQ-029 aluc 0111: A&B.
REQ-030 aluc 1000: A^B.
REQ-031 aluc 1001: A-B; CY = borrow.
REQ-032 aluc 1010: B+1; CY = carry out.
REQ-033 aluc 1011: CY:=0, result A.
REQ-034 aluc 1100: CY:=1, result A.
REQ-035 aluc 1101-1111: result B, flags unchanged.
REQ-036 CY is unchanged by every aluc code not listed above as writing it.
REQ-037 CY is updated at the stage-2 edge, so an ADC issued in the cycle immediately after a CY set/clear sees the new value.
REQ-038 Shifter, applied after the ALU: 000 none, 001 shl1, 010 shr1 (logical), 011 shl16, 100 shr16 (logical), 101 sar1, 110 rol1, 111 ror1.
REQ-039 Stage 3, read=1: mem_read=1, mem_addr_bus = result, and mem_data_bus is written to R[c] instead of result.
REQ-040 Stage 3, write=1: mem_write=1, mem_addr_bus = result, and mem_data_bus driven with the latched B operand.
REQ-041 read=1 and write=1 together: write takes priority and read is ignored.
REQ-042 Stage 3, print=1: the result is registered into output_port0 when flip=0, or into output_port1 when flip=1; the other port holds its value.

Reset
REQ-043 rst_n=0 asynchronously clears R0-R59, CY, Z, N, output_port0/1, mem_addr_bus, mem_read and mem_write to 0.
REQ-044 rst_n=0 forces all pipeline stages to NOP (c=63, read=write=print=0); mem_data_bus goes high-Z.
REQ-045 Reset asserted mid-pipeline discards all in-flight instructions with no writeback.

Structure
REQ-046 Shared package ev21g1_pkg holds the field positions and widths, the aluc and sh encodings, and the constants NULL_REG=63, IN0_REG=60 and IN1_REG=61.
REQ-047 One sub-module, ev21g1_alu, contains the combinational ALU, shifter and carry logic; the register file and pipeline registers stay in the top level.

Verification
REQ-048 Load immediates: k=0,1,2 with kmx=1, aluc=0000, sh=000 into R0-R2, then 2 NOPs -> R0=0, R1=1, R2=2.
REQ-049 Shifted immediate and NOT: k=3, sh=011 into R3 -> R3=0x00030000; then R13=~R3 -> R13=0xFFFCFFFF; R3+R13 -> R20=0xFFFFFFFF, CY=0.
REQ-050 Logic operations: R20 AND R13 -> R21=0xFFFCFFFF; R3 OR R2 -> R22=0x00030002.
REQ-051 Carry chain: CY=1 followed immediately by ADC R3+R13 -> R20=0x00000000, CY=1.
REQ-052 Overflow sum: R24=0x8000<<16 and R23=(0xFFFF<<16)|0xFFFF, then R24+R23 -> R25=0x7FFFFFFF, CY=1.
REQ-053 Ports and memory: print with flip=1 shows R25 on output_port1 only; write=1 drives mem_data_bus with B and mem_addr_bus with the result for one cycle; assert rst_n mid-sequence -> all outputs 0 and no writeback.
